hilo_mac_unit: RTL and testbench

Multi-cycle multiply / multiply-accumulate engine in the EX stage, directly downstream of the ALU. It owns the architectural HI/LO registers; its Hi/Lo outputs drive the ALU's Hi_in/Lo_in.
- Executes mult, multu, madd, msub, mthi and mtlo.
- Uses an iterative shift-add datapath and a Busy handshake so hazard logic can stall the pipeline.

---
 rtl/hilo_mac_unit_pkg.sv | 25 ++
 rtl/hilo_mac_unit_if.sv | 22 ++
 rtl/hilo_mult_step.sv | 24 ++
 rtl/hilo_mac_unit.sv | 136 +++++++++++++
 tb/tb_hilo_mac_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_mac_unit_pkg.sv
// rtl/hilo_mac_unit_pkg.sv - op encodings, FSM states and step-count helper for the HI/LO MAC unit
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MSUB  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int ITER_BITS_DEFAULT = 1;

    // RUN cycles needed to retire all 32 multiplier bits.
    function automatic int num_steps(input int iter_bits);
        return 32 / iter_bits;
    endfunction

endpackage

// File: rtl/hilo_mac_unit_if.sv
// rtl/hilo_mac_unit_if.sv - request/result bundle between EX-stage control and the HI/LO MAC unit
interface hilo_mac_unit_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, A, B, Cancel,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, Cancel,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/hilo_mult_step.sv
// rtl/hilo_mult_step.sv - one combinational shift-add iteration retiring ITER_BITS multiplier bits
module hilo_mult_step #(
    parameter int ITER_BITS = 1
) (
    input  logic [63:0] acc_i,
    input  logic [63:0] mcand_i,
    input  logic [31:0] mplier_i,
    output logic [63:0] acc_o,
    output logic [63:0] mcand_o,
    output logic [31:0] mplier_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (mplier_i[i]) begin
                acc_o = acc_o + (mcand_i << i);
            end
        end
        mcand_o  = mcand_i << ITER_BITS;
        mplier_o = mplier_i >> ITER_BITS;
    end

endmodule

// File: rtl/hilo_mac_unit.sv
// rtl/hilo_mac_unit.sv - iterative multiply / multiply-accumulate engine owning architectural HI/LO
module hilo_mac_unit
    import hilo_pkg::*;
#(
    parameter int ITER_BITS = ITER_BITS_DEFAULT
) (
    input  logic          Clk,
    input  logic          Reset,
    hilo_mac_unit_if.slave mac
);

    localparam int N  = num_steps(ITER_BITS);
    localparam int CW = $clog2(N);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    mcand_q, mcand_d;
    logic [31:0]    mplier_q, mplier_d;
    logic [63:0]    acc_q, acc_d;
    logic           neg_q, neg_d;
    logic [2:0]     op_q, op_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic           done_q, done_d;

    logic [63:0]    step_acc, step_mcand;
    logic [31:0]    step_mplier;
    logic [63:0]    prod, result;
    logic           sgn;
    logic [31:0]    a_mag, b_mag;

    hilo_mult_step #(.ITER_BITS(ITER_BITS)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (step_acc),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier)
    );

    // Signed ops multiply magnitudes; 0x80000000 negates to itself, which is 2^31 unsigned.
    always_comb begin
        sgn   = (mac.Op != OP_MULTU);
        a_mag = (sgn && mac.A[31]) ? (~mac.A + 32'd1) : mac.A;
        b_mag = (sgn && mac.B[31]) ? (~mac.B + 32'd1) : mac.B;
        prod  = neg_q ? (~step_acc + 64'd1) : step_acc;
        case (op_q)
            OP_MADD: result = {hi_q, lo_q} + prod;
            OP_MSUB: result = {hi_q, lo_q} - prod;
            default: result = prod;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mac.Start && !mac.Cancel) begin
                    case (mac.Op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            state_d  = RUN;
                            cnt_d    = '0;
                            mcand_d  = {32'd0, a_mag};
                            mplier_d = b_mag;
                            acc_d    = '0;
                            neg_d    = sgn && (mac.A[31] ^ mac.B[31]);
                            op_d     = mac.Op;
                        end
                        OP_MTHI: hi_d = mac.A;
                        OP_MTLO: lo_d = mac.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Cancel wins even on the completing edge.
                if (mac.Cancel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    acc_d    = step_acc;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = IDLE;
                        hi_d    = result[63:32];
                        lo_d    = result[31:0];
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign mac.Busy = (state_q == RUN);
    assign mac.Done = done_q;
    assign mac.Hi   = hi_q;
    assign mac.Lo   = lo_q;

endmodule

// File: tb/tb_hilo_mac_unit.sv
// tb/tb_hilo_mac_unit.sv - directed self-checking bench for hilo_mac_unit with ITER_BITS=1
module tb_hilo_mac_unit;
    import hilo_pkg::*;

    localparam int N = 32;

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    hilo_mac_unit_if mac ();

    hilo_mac_unit #(.ITER_BITS(1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .mac   (mac)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        mac.Start = 1'b1;
        mac.Op    = op;
        mac.A     = a;
        mac.B     = b;
        @(negedge Clk);
        mac.Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (mac.Busy && n < 100) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_cmp++; if (mac.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", mac.Busy); end
        n_cmp++; if (mac.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", mac.Done); end
        n_cmp++; if (mac.Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", mac.Lo); end
        Reset = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        drive_op(OP_MULT, 32'd3, 32'hFFFF_FFFB);
        wait_idle(n);
        n_cmp++; if (n !== N) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want %0d", n, N); end
        n_cmp++; if (mac.Done !== 1'b1) begin n_fail++; $display("FAIL mult_done got %0b want 1", mac.Done); end
        n_cmp++; if (mac.Hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got %h want fffffff1", mac.Lo); end
        @(negedge Clk);
        n_cmp++; if (mac.Done !== 1'b0) begin n_fail++; $display("FAIL done_one_pulse got %0b want 0", mac.Done); end

        drive_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        n_cmp++; if (mac.Hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", mac.Lo); end

        drive_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle(n);
        n_cmp++; if (mac.Hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi got %h want 40000000", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'h0) begin n_fail++; $display("FAIL mult_min_lo got %h want 0", mac.Lo); end
    endtask

    task automatic test_accumulate();
        int n;
        drive_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        n_cmp++; if (mac.Busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got %0b want 0", mac.Busy); end
        n_cmp++; if (mac.Lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mtlo_lo got %h want ffffffff", mac.Lo); end
        drive_op(OP_MTHI, 32'h0, 32'h0);
        n_cmp++; if (mac.Hi !== 32'h0) begin n_fail++; $display("FAIL mthi_hi got %h want 0", mac.Hi); end
        n_cmp++; if (mac.Done !== 1'b0) begin n_fail++; $display("FAIL mthi_done got %0b want 0", mac.Done); end
        drive_op(OP_MADD, 32'd1, 32'd1);
        wait_idle(n);
        n_cmp++; if (mac.Hi !== 32'h1) begin n_fail++; $display("FAIL madd_hi got %h want 00000001", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'h0) begin n_fail++; $display("FAIL madd_lo got %h want 0", mac.Lo); end

        drive_op(OP_MTHI, 32'h0, 32'h0);
        drive_op(OP_MTLO, 32'h0, 32'h0);
        drive_op(OP_MSUB, 32'd2, 32'd3);
        wait_idle(n);
        n_cmp++; if (mac.Hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL msub_hi got %h want ffffffff", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL msub_lo got %h want fffffffa", mac.Lo); end
    endtask

    task automatic test_busy_ignore_and_cancel();
        int n;
        int dones;
        drive_op(OP_MULT, 32'd7, 32'd6);
        repeat (3) @(negedge Clk);
        mac.Start = 1'b1;
        mac.Op    = OP_MTHI;
        mac.A     = 32'h1234;
        @(negedge Clk);
        mac.Start = 1'b0;
        wait_idle(n);
        n_cmp++; if (mac.Done !== 1'b1) begin n_fail++; $display("FAIL busy_ign_done got %0b want 1", mac.Done); end
        n_cmp++; if (mac.Hi !== 32'h0) begin n_fail++; $display("FAIL busy_ign_hi got %h want 0", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'd42) begin n_fail++; $display("FAIL busy_ign_lo got %h want 0000002a", mac.Lo); end

        drive_op(OP_MULT, 32'd5, 32'd5);
        repeat (9) @(negedge Clk);
        mac.Cancel = 1'b1;
        @(negedge Clk);
        mac.Cancel = 1'b0;
        n_cmp++; if (mac.Busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %0b want 0", mac.Busy); end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (mac.Done === 1'b1) dones++;
            @(negedge Clk);
        end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL cancel_no_done got %0d pulses want 0", dones); end
        n_cmp++; if (mac.Lo !== 32'd42) begin n_fail++; $display("FAIL cancel_lo got %h want 0000002a", mac.Lo); end

        mac.Cancel = 1'b1;
        drive_op(OP_MTHI, 32'hDEAD, 32'h0);
        mac.Cancel = 1'b0;
        n_cmp++; if (mac.Hi !== 32'h0) begin n_fail++; $display("FAIL idle_cancel_hi got %h want 0", mac.Hi); end

        drive_op(3'd7, 32'h55, 32'h55);
        n_cmp++; if (mac.Busy !== 1'b0) begin n_fail++; $display("FAIL undef_busy got %0b want 0", mac.Busy); end
        n_cmp++; if (mac.Lo !== 32'd42) begin n_fail++; $display("FAIL undef_lo got %h want 0000002a", mac.Lo); end
    endtask

    task automatic test_reset_mid_run();
        drive_op(OP_MTHI, 32'h5555, 32'h0);
        drive_op(OP_MULT, 32'd9, 32'd9);
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_cmp++; if (mac.Busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_busy got %0b want 0", mac.Busy); end
        n_cmp++; if (mac.Hi !== 32'h0) begin n_fail++; $display("FAIL rst_run_hi got %h want 0", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'h0) begin n_fail++; $display("FAIL rst_run_lo got %h want 0", mac.Lo); end
        n_cmp++; if (mac.Done !== 1'b0) begin n_fail++; $display("FAIL rst_run_done got %0b want 0", mac.Done); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        int c1;
        int c2;
        drive_op(OP_MULT, 32'd2, 32'd3);
        wait_idle(n);
        n_cmp++; if (mac.Done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got %0b want 1", mac.Done); end
        n_cmp++; if (mac.Lo !== 32'd6) begin n_fail++; $display("FAIL b2b_lo1 got %h want 00000006", mac.Lo); end
        c1 = cyc;
        mac.Start = 1'b1;
        mac.Op    = OP_MULT;
        mac.A     = 32'd4;
        mac.B     = 32'hFFFF_FFFB;
        @(negedge Clk);
        mac.Start = 1'b0;
        n = 0;
        while (mac.Done !== 1'b1 && n < 100) begin
            n++;
            @(negedge Clk);
        end
        c2 = cyc;
        n_cmp++; if ((c2 - c1) !== N + 1) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", c2 - c1, N + 1); end
        n_cmp++; if (mac.Hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_hi2 got %h want ffffffff", mac.Hi); end
        n_cmp++; if (mac.Lo !== 32'hFFFF_FFEC) begin n_fail++; $display("FAIL b2b_lo2 got %h want ffffffec", mac.Lo); end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        mac.Start  = 1'b0;
        mac.Op     = 3'd0;
        mac.A      = 32'h0;
        mac.B      = 32'h0;
        mac.Cancel = 1'b0;
        test_reset();
        test_mult();
        test_accumulate();
        test_busy_ignore_and_cancel();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
